// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared types and constants for the RV32I core front end.
//                XLEN, the canonical NOP encoding, the fetch-stage state
//                enum, the fetch-queue entry type and an address helper.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_pkg;

    localparam int              XLEN      = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;   // addi x0, x0, 0

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            misaligned;
    } fetch_entry_t;

    // Force an address onto a 32-bit word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_buffer
//  Description : Two-entry FIFO of fetch entries sitting between the
//                instruction memory response and decode.
//  Ports       : clk, rst (async, active-high)
//                push / push_entry : write one entry at the tail
//                pop               : retire the head entry
//                flush             : drop all contents (beats push)
//                count             : number of valid entries (0..2)
//                head              : entry at the head of the queue
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    logic         w_pop;
    logic         w_push;

    // A pop on an empty queue is ignored; a push into a full queue is only
    // taken when the head leaves in the same cycle, so nothing is overwritten.
    assign w_pop  = pop && (r_count != 2'd0);
    assign w_push = push && ((r_count != 2'(DEPTH)) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule : fetch_buffer
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : RV32I instruction-fetch stage. Holds the PC, issues word
//                reads to a 1-cycle-latency synchronous instruction memory,
//                queues returned words and hands {instr, pc} to decode over
//                a valid/ready handshake. Execute redirects flush the queue
//                and restart fetching at the (word-aligned) target.
//  Ports       : clk, rst (async, active-high)
//                imem_req/imem_addr/imem_rdata : instruction memory port
//                redirect_valid/redirect_pc    : branch/jump target from EX
//                if_valid/id_ready             : handshake to decode
//                if_instr/if_pc/if_misaligned  : entry presented to decode
//                perf_fetched/perf_bubbles     : only with FETCH_PERF_EN
//  Options     : `define FETCH_PERF_EN adds pop and bubble counters.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2              // only 2 is supported
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_misaligned
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_inflight;       // a read issued last cycle returns now
    logic [31:0]  r_inflight_pc;
    logic         r_inflight_mis;
    logic [31:0]  r_last_pc;        // if_pc value shown while the queue is empty

    logic [1:0]   w_count;
    fetch_entry_t w_head;
    fetch_entry_t w_push_entry;
    logic         w_pop;
    logic         w_kill;
    logic         w_push;
    logic [2:0]   w_occupancy;
    logic         w_room;
    logic [31:0]  w_redirect_addr;
    logic         w_redirect_mis;

    assign w_pop           = if_valid && id_ready;
    assign w_redirect_addr = align_word(redirect_pc);
    assign w_redirect_mis  = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // The response returning this cycle belongs to the old stream when a
    // redirect arrives, so it is dropped instead of being queued.
    assign w_kill = redirect_valid;
    assign w_push = r_inflight && !w_kill;

    // Slots that will be taken once everything in flight has landed; a new
    // request is only issued when its data is guaranteed a free slot.
    assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_room      = (w_occupancy < 3'(BUF_DEPTH));

    assign imem_req  = redirect_valid || ((r_state == RUN) && w_room);
    assign imem_addr = redirect_valid ? w_redirect_addr : r_pc;

    assign w_push_entry = '{instr: imem_rdata, pc: r_inflight_pc, misaligned: r_inflight_mis};

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .flush      (redirect_valid),
        .count      (w_count),
        .head       (w_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= BOOT;
            r_pc           <= RESET_PC;
            r_inflight     <= 1'b0;
            r_inflight_pc  <= RESET_PC;
            r_inflight_mis <= 1'b0;
            r_last_pc      <= '0;
        end else begin
            case (r_state)
                BOOT:    r_state <= RUN;
                RUN:     r_state <= RUN;
                default: r_state <= BOOT;
            endcase
            r_inflight <= imem_req;
            if (imem_req) begin
                r_inflight_pc  <= imem_addr;
                r_inflight_mis <= w_redirect_mis;
                r_pc           <= imem_addr + 32'd4;
            end
            if (if_valid) begin
                r_last_pc <= w_head.pc;
            end
        end
    end

    assign if_valid      = (w_count != 2'd0);
    assign if_instr      = if_valid ? w_head.instr : NOP_INSTR;
    assign if_pc         = if_valid ? w_head.pc : r_last_pc;
    assign if_misaligned = if_valid && w_head.misaligned;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubbles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_bubbles <= '0;
        end else begin
            if (w_pop) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if ((r_state == RUN) && id_ready && !if_valid) begin
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubbles = r_perf_bubbles;
`endif

endmodule : fetch_unit
`default_nettype wire
